pipeline_driver: RTL and testbench

// Drives the far end of the pipeline's two valid/ready channels.
// - Data side: produces a stream of COUNT 16-bit words from a Galois LFSR.
// - Result side: consumes returned results, counts them and folds them

---
 rtl/pipeline_driver.sv | 160 ++++++++++++++++
 tb/tb_pipeline_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_driver.sv
// rtl/pipeline_driver.sv - LFSR data source and checksumming result sink for a valid/ready pipeline
//
// Purpose: sends COUNT pseudo-random words into a pipeline, absorbs the returned
// results into a count and a rotating XOR checksum, and aborts the run with
// error=1 if neither channel moves for TIMEOUT consecutive cycles.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   start                    1-cycle pulse, starts a run from IDLE or FINISH
//   data, data_valid         outgoing word channel (data_ready from the pipeline)
//   result, result_valid     returned word channel (result_ready to the pipeline)
//   busy, finished, error    run status
//   sent_count, recv_count   transfers completed on each channel this run
//   checksum                 folded result checksum for this run
module pipeline_driver #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [15:0] COUNT   = 16'd256,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  input  logic [15:0] result,
  input  logic        result_valid,
  output logic        result_ready,
  output logic        busy,
  output logic        finished,
  output logic        error,
  output logic [15:0] sent_count,
  output logic [15:0] recv_count,
  output logic [15:0] checksum
);

  // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [15:0] idle_cnt;
  logic        data_xfer;
  logic        result_xfer;
  logic        launch;
  logic        timeout_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_valid   = 1'b0;
    result_ready = 1'b0;
    busy         = 1'b0;
    finished     = 1'b0;
    launch       = 1'b0;
    data_xfer    = 1'b0;
    result_xfer  = 1'b0;
    timeout_hit  = 1'b0;

    case (state)
      S_RUN: begin
        busy         = 1'b1;
        result_ready = 1'b1;
        data_valid   = (sent_count < COUNT);
      end
      S_DRAIN: begin
        busy         = 1'b1;
        result_ready = 1'b1;
      end
      S_FINISH: begin
        finished = 1'b1;
      end
      default: ;
    endcase

    data_xfer   = data_valid & data_ready;
    result_xfer = result_valid & result_ready;
    // The idle count that would be reached this edge hits the limit.
    timeout_hit = busy & ~data_xfer & ~result_xfer & ((idle_cnt + 16'd1) == TIMEOUT);

    case (state)
      S_IDLE, S_FINISH: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (data_xfer && ((sent_count + 16'd1) == COUNT)) begin
          state_nxt = S_DRAIN;
        end else if (timeout_hit) begin
          state_nxt = S_FINISH;
        end
      end
      S_DRAIN: begin
        if (recv_count == sent_count) begin
          state_nxt = S_FINISH;
        end else if (timeout_hit) begin
          state_nxt = S_FINISH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data is forced to zero when not offered so every output is 0 in reset/IDLE.
  assign data = data_valid ? lfsr : 16'h0000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr       <= SEED_EFF;
      sent_count <= 16'h0000;
      recv_count <= 16'h0000;
      checksum   <= 16'h0000;
      error      <= 1'b0;
      idle_cnt   <= 16'h0000;
    end else if (launch) begin
      lfsr       <= SEED_EFF;
      sent_count <= 16'h0000;
      recv_count <= 16'h0000;
      checksum   <= 16'h0000;
      error      <= 1'b0;
      idle_cnt   <= 16'h0000;
    end else begin
      if (data_xfer) begin
        sent_count <= sent_count + 16'd1;
        lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
      end
      if (result_xfer) begin
        if (recv_count != 16'hFFFF) begin
          recv_count <= recv_count + 16'd1;
        end
        checksum <= {checksum[14:0], checksum[15]} ^ result;
      end
      if (busy) begin
        idle_cnt <= (data_xfer | result_xfer) ? 16'h0000 : idle_cnt + 16'd1;
      end
      if (timeout_hit) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_driver.sv
// tb/tb_pipeline_driver.sv - self-checking bench for pipeline_driver
module tb_pipeline_driver;

  logic clock;
  logic reset;

  logic        a_start, a_data_ready, a_result_valid;
  logic [15:0] a_result;
  logic [15:0] a_data, a_sent, a_recv, a_checksum;
  logic        a_data_valid, a_result_ready, a_busy, a_finished, a_error;

  logic        b_start, b_data_ready, b_result_valid;
  logic [15:0] b_result;
  logic [15:0] b_data, b_sent, b_recv, b_checksum;
  logic        b_data_valid, b_result_ready, b_busy, b_finished, b_error;

  int checks;
  int errors;

  pipeline_driver #(.SEED(16'hACE1), .COUNT(16'd2), .TIMEOUT(16'd16)) u_a (
    .clock(clock), .reset(reset), .start(a_start),
    .data(a_data), .data_valid(a_data_valid), .data_ready(a_data_ready),
    .result(a_result), .result_valid(a_result_valid), .result_ready(a_result_ready),
    .busy(a_busy), .finished(a_finished), .error(a_error),
    .sent_count(a_sent), .recv_count(a_recv), .checksum(a_checksum)
  );

  pipeline_driver #(.SEED(16'hACE1), .COUNT(16'd4), .TIMEOUT(16'd8)) u_b (
    .clock(clock), .reset(reset), .start(b_start),
    .data(b_data), .data_valid(b_data_valid), .data_ready(b_data_ready),
    .result(b_result), .result_valid(b_result_valid), .result_ready(b_result_ready),
    .busy(b_busy), .finished(b_finished), .error(b_error),
    .sent_count(b_sent), .recv_count(b_recv), .checksum(b_checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each row: inputs applied for the next edge, and the outputs expected just
  // before that edge (i.e. the state left by the previous edge).
  typedef struct packed {
    logic        start;
    logic        dr;
    logic        rv;
    logic [15:0] res;
    logic        e_dv;
    logic [15:0] e_data;
    logic [15:0] e_sent;
    logic [15:0] e_recv;
    logic [15:0] e_cs;
    logic        e_rr;
    logic        e_busy;
    logic        e_fin;
    logic        e_err;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  logic [15:0] exp_seq [4];
  int          words;
  int          last_xfer;
  int          fin_at;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    a_start = 0; a_data_ready = 0; a_result_valid = 0; a_result = 0;
    b_start = 0; b_data_ready = 0; b_result_valid = 0; b_result = 0;

    //            st dr rv res       dv data      sent   recv   cs        rr bs fn er
    tbl[0]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'd0,16'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'd0,16'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,16'h0001, 1'b1,16'hE270,16'd1,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,16'h0002, 1'b0,16'h0000,16'd2,16'd1,16'h0001, 1'b1,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'd2,16'd2,16'h0000, 1'b1,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,16'hFFFF, 1'b0,16'h0000,16'd2,16'd2,16'h0000, 1'b0,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'd2,16'd2,16'h0000, 1'b0,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hACE1,16'd0,16'd0,16'h0000, 1'b1,1'b1,1'b0,1'b0};

    exp_seq[0] = 16'hACE1;
    exp_seq[1] = 16'hE270;
    exp_seq[2] = 16'h7138;
    exp_seq[3] = 16'h389C;

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Table-driven run on u_a: stall, ignored start, drain, FINISH, restart.
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      check($sformatf("row%0d data_valid", i),   {15'd0, a_data_valid},   {15'd0, tbl[i].e_dv});
      check($sformatf("row%0d data", i),         a_data,                  tbl[i].e_data);
      check($sformatf("row%0d sent_count", i),   a_sent,                  tbl[i].e_sent);
      check($sformatf("row%0d recv_count", i),   a_recv,                  tbl[i].e_recv);
      check($sformatf("row%0d checksum", i),     a_checksum,              tbl[i].e_cs);
      check($sformatf("row%0d result_ready", i), {15'd0, a_result_ready}, {15'd0, tbl[i].e_rr});
      check($sformatf("row%0d busy", i),         {15'd0, a_busy},         {15'd0, tbl[i].e_busy});
      check($sformatf("row%0d finished", i),     {15'd0, a_finished},     {15'd0, tbl[i].e_fin});
      check($sformatf("row%0d error", i),        {15'd0, a_error},        {15'd0, tbl[i].e_err});
      a_start        = tbl[i].start;
      a_data_ready   = tbl[i].dr;
      a_result_valid = tbl[i].rv;
      a_result       = tbl[i].res;
    end
    @(negedge clock);
    a_start = 0; a_data_ready = 0; a_result_valid = 0;

    // Timeout on u_b: four words sent, nothing returned.
    b_start = 1'b1;
    b_data_ready = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    words = 0;
    last_xfer = -1;
    fin_at = -1;
    for (int i = 0; i < 100; i++) begin
      if (b_finished) begin
        fin_at = i;
        break;
      end
      if (b_data_valid) begin
        if (words < 4) check($sformatf("lfsr word%0d", words), b_data, exp_seq[words]);
        words++;
        last_xfer = i;
      end
      @(negedge clock);
    end
    if (fin_at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_wait: finished never rose within 100 cycles");
    end else begin
      check("timeout idle cycles", 16'(fin_at - last_xfer - 1), 16'd8);
    end
    check("timeout words", 16'(words), 16'd4);
    check("timeout error", {15'd0, b_error}, 16'd1);
    check("timeout recv_count", b_recv, 16'd0);
    check("timeout sent_count", b_sent, 16'd4);

    // Reset mid-run on u_b, then replay from SEED.
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    check("rerun error cleared", {15'd0, b_error}, 16'd0);
    check("rerun first word", b_data, 16'hACE1);
    @(negedge clock);
    check("rerun second word", b_data, 16'hE270);
    check("rerun data_valid", {15'd0, b_data_valid}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async data_valid", {15'd0, b_data_valid}, 16'd0);
    check("async data", b_data, 16'h0000);
    check("async sent_count", b_sent, 16'h0000);
    check("async busy", {15'd0, b_busy}, 16'd0);
    check("async result_ready", {15'd0, b_result_ready}, 16'd0);
    check("async finished", {15'd0, b_finished}, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post reset idle", {15'd0, b_data_valid}, 16'd0);
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    check("replay data_valid", {15'd0, b_data_valid}, 16'd1);
    check("replay first word", b_data, 16'hACE1);
    check("replay sent_count", b_sent, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
